// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the exception controller: CP0 register
// addresses, MIPS exception codes, FSM state encoding and the debug view.
package exc_ctrl_pkg;

    // Default handler entry for every exception and interrupt.
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // CP0 register addresses touched by the write-back sequence.
    localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

    // ExcCode values written into Cause[6:2].
    localparam logic [4:0] EXC_CODE_INT = 5'h00;
    localparam logic [4:0] EXC_CODE_RI  = 5'h0a;
    localparam logic [4:0] EXC_CODE_OV  = 5'h0c;
    localparam logic [4:0] EXC_CODE_SYS = 5'h08;
    localparam logic [4:0] EXC_CODE_BP  = 5'h09;

    // Status bit positions used by the controller.
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_EPC    = 3'd1,
        ST_W_CAUSE  = 3'd2,
        ST_W_STATUS = 3'd3,
        ST_W_ERET   = 3'd4
    } exc_state_e;

    // Everything latched at the event cycle, exposed for observation.
    typedef struct packed {
        exc_state_e  state;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] status;
    } exc_dbg_t;

    // EPC points at the branch when the faulting instruction is in its delay slot.
    function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Signal bundle between the pipeline/CP0 and the exception controller.
//
// There is no valid/ready handshake here. The MEM-stage fields are
// qualified by mem_valid and are only sampled while the controller is
// idle (stall_o=0). cp0_we is a single-cycle write strobe that CP0 must
// accept unconditionally in the same cycle; cp0_hw_we only has meaning
// while cp0_we=1. flush_o/new_pc_o form a one-cycle redirect pulse.
interface exc_ctrl_if;

    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delay;
    logic [3:0]  mem_excflags;
    logic        mem_eret;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;

    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        cp0_hw_we;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_o;

    // Pipeline / CP0 side.
    modport master (
        output mem_valid, mem_pc, mem_in_delay, mem_excflags, mem_eret,
        output mtc0_we, mtc0_addr, mtc0_wdata,
        output status_i, cause_i, epc_i,
        input  cp0_we, cp0_waddr, cp0_wdata, cp0_hw_we,
        input  flush_o, new_pc_o, stall_o
    );

    // Exception controller side.
    modport slave (
        input  mem_valid, mem_pc, mem_in_delay, mem_excflags, mem_eret,
        input  mtc0_we, mtc0_addr, mtc0_wdata,
        input  status_i, cause_i, epc_i,
        output cp0_we, cp0_waddr, cp0_wdata, cp0_hw_we,
        output flush_o, new_pc_o, stall_o
    );

endinterface

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority event selector: interrupt > ri > ovf > syscall > break,
// with ERET reported only when none of those is present.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic       i_mem_valid,
    input  logic       i_int_pending,
    input  logic [3:0] i_excflags,   // {ri, ovf, syscall, break}
    input  logic       i_eret,
    output logic       o_exc_valid,
    output logic [4:0] o_exc_code,
    output logic       o_eret_valid
);

    // Pick the highest-priority event; nothing counts without a real instruction.
    always_comb begin
        o_exc_valid  = 1'b0;
        o_exc_code   = EXC_CODE_INT;
        o_eret_valid = 1'b0;
        if (i_mem_valid) begin
            if (i_int_pending) begin
                o_exc_valid = 1'b1;
                o_exc_code  = EXC_CODE_INT;
            end else if (i_excflags[3]) begin
                o_exc_valid = 1'b1;
                o_exc_code  = EXC_CODE_RI;
            end else if (i_excflags[2]) begin
                o_exc_valid = 1'b1;
                o_exc_code  = EXC_CODE_OV;
            end else if (i_excflags[1]) begin
                o_exc_valid = 1'b1;
                o_exc_code  = EXC_CODE_SYS;
            end else if (i_excflags[0]) begin
                o_exc_valid = 1'b1;
                o_exc_code  = EXC_CODE_BP;
            end else if (i_eret) begin
                o_eret_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: detects MEM-stage exceptions, interrupts and ERET,
// flushes the pipeline and then sequences the EPC/Cause/Status updates
// through the single CP0 write port while holding the pipeline stalled.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    exc_ctrl_if.slave  bus,
    output exc_dbg_t   o_dbg
);

    exc_state_e  r_state;
    logic [4:0]  r_code;
    logic        r_bd;
    logic [31:0] r_pc;
    logic [31:0] r_status;

    logic        w_int_pending;
    logic        w_exc_valid;
    logic [4:0]  w_exc_code;
    logic        w_eret_valid;

    logic        w_cp0_we;
    logic [4:0]  w_cp0_waddr;
    logic [31:0] w_cp0_wdata;
    logic        w_cp0_hw_we;
    logic        w_flush;
    logic [31:0] w_new_pc;
    logic        w_stall;

    // Interrupt pending: enabled, not already in exception level, and a masked line raised.
    assign w_int_pending = bus.mem_valid
                         & bus.status_i[STATUS_IE_BIT]
                         & ~bus.status_i[STATUS_EXL_BIT]
                         & (|(bus.status_i[15:8] & bus.cause_i[15:8]));

    exc_prio u_prio (
        .i_mem_valid   (bus.mem_valid),
        .i_int_pending (w_int_pending),
        .i_excflags    (bus.mem_excflags),
        .i_eret        (bus.mem_eret),
        .o_exc_valid   (w_exc_valid),
        .o_exc_code    (w_exc_code),
        .o_eret_valid  (w_eret_valid)
    );

    // Sequencer: latch the event in IDLE, then walk the CP0 write-back states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_code   <= '0;
            r_bd     <= 1'b0;
            r_pc     <= '0;
            r_status <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_exc_valid) begin
                        r_code   <= w_exc_code;
                        r_bd     <= bus.mem_in_delay;
                        r_pc     <= bus.mem_pc;
                        r_status <= bus.status_i;
                        // Nested entry (EXL already set) keeps the original EPC.
                        r_state  <= bus.status_i[STATUS_EXL_BIT] ? ST_W_CAUSE : ST_W_EPC;
                    end else if (w_eret_valid) begin
                        r_state <= ST_W_ERET;
                    end
                end
                ST_W_EPC:    r_state <= ST_W_CAUSE;
                ST_W_CAUSE:  r_state <= ST_W_STATUS;
                ST_W_STATUS: r_state <= ST_IDLE;
                ST_W_ERET:   r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    // CP0 write port, redirect and stall; everything forced low while reset is held.
    always_comb begin
        w_cp0_we    = 1'b0;
        w_cp0_waddr = '0;
        w_cp0_wdata = '0;
        w_cp0_hw_we = 1'b0;
        w_flush     = 1'b0;
        w_new_pc    = '0;
        w_stall     = 1'b0;
        if (rst) begin
            w_stall = (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_exc_valid) begin
                        w_flush  = 1'b1;
                        w_new_pc = EXC_VECTOR;
                    end else if (w_eret_valid) begin
                        w_flush  = 1'b1;
                        w_new_pc = bus.epc_i;
                    end else begin
                        // No event: the pipeline's MTC0 owns the write port.
                        w_cp0_we    = bus.mtc0_we;
                        w_cp0_waddr = bus.mtc0_addr;
                        w_cp0_wdata = bus.mtc0_wdata;
                    end
                end
                ST_W_EPC: begin
                    w_cp0_we    = 1'b1;
                    w_cp0_waddr = CP0_ADDR_EPC;
                    w_cp0_wdata = epc_value(r_pc, r_bd);
                end
                ST_W_CAUSE: begin
                    w_cp0_we    = 1'b1;
                    w_cp0_hw_we = 1'b1;
                    w_cp0_waddr = CP0_ADDR_CAUSE;
                    w_cp0_wdata = {r_bd, bus.cause_i[30:7], r_code, bus.cause_i[1:0]};
                end
                ST_W_STATUS: begin
                    w_cp0_we    = 1'b1;
                    w_cp0_waddr = CP0_ADDR_STATUS;
                    w_cp0_wdata = bus.status_i | 32'h0000_0002;
                end
                ST_W_ERET: begin
                    w_cp0_we    = 1'b1;
                    w_cp0_waddr = CP0_ADDR_STATUS;
                    w_cp0_wdata = bus.status_i & ~32'h0000_0002;
                end
                default: begin
                    w_cp0_we = 1'b0;
                end
            endcase
        end
    end

    assign bus.cp0_we    = w_cp0_we;
    assign bus.cp0_waddr = w_cp0_waddr;
    assign bus.cp0_wdata = w_cp0_wdata;
    assign bus.cp0_hw_we = w_cp0_hw_we;
    assign bus.flush_o   = w_flush;
    assign bus.new_pc_o  = w_new_pc;
    assign bus.stall_o   = w_stall;

    assign o_dbg = '{state: r_state, code: r_code, bd: r_bd, pc: r_pc, status: r_status};

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020: handler entry PC for all exceptions and interrupts.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 mem_valid  input  1  MEM stage holds a real instruction.
REQ-005 mem_pc  input  32  PC of MEM-stage instruction.
REQ-006 mem_in_delay  input  1  MEM instruction sits in a branch delay slot.
REQ-007 mem_excflags  input  4  {ri, ovf, syscall, break} raised by MEM instruction.
REQ-008 mem_eret  input  1  MEM instruction is ERET.
REQ-009 mtc0_we, mtc0_addr, mtc0_wdata  input  1/5/32  pipeline MTC0 write request.
REQ-010 status_i, cause_i, epc_i  input  32 each  current CP0 Status/Cause/EPC.
REQ-011 cp0_we, cp0_waddr, cp0_wdata  output  1/5/32  single CP0 write port.
REQ-012 cp0_hw_we  output  1  qualifies a Cause write as a hardware write (CP0 honours bits 31 and 6:2).
REQ-013 flush_o  output  1  flush whole pipeline this cycle.
REQ-014 new_pc_o  output  32  redirect PC, valid when flush_o=1.
REQ-015 stall_o  output  1  freeze pipeline while CP0 write-back sequence runs.

Function
REQ-016 Interrupt pending SHALL be mem_valid & status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]).
REQ-017 Priority SHALL be interrupt > ri > ovf > syscall > break > eret; ExcCode 0x00, 0x0a, 0x0c, 0x08, 0x09 respectively; flags ignored unless mem_valid=1.
REQ-018 States SHALL be IDLE, W_EPC, W_CAUSE, W_STATUS, W_ERET.
REQ-019 In IDLE on any exception/interrupt: flush_o=1, new_pc_o=EXC_VECTOR combinationally in that cycle; latch code, mem_pc, mem_in_delay, status_i; next state W_EPC, or W_CAUSE if latched Status.EXL=1 (EPC not overwritten).
REQ-020 W_EPC SHALL write CP0 addr 14 with bd ? pc-4 : pc (32-bit wrap), then go W_CAUSE.
REQ-021 W_CAUSE SHALL write addr 13 with cause_i, bit31=bd, bits6:2=code, cp0_hw_we=1, then go W_STATUS.
REQ-022 W_STATUS SHALL write addr 12 with status_i | 32'h2 (EXL set), then go IDLE.
REQ-023 In IDLE on ERET with no higher-priority event: flush_o=1, new_pc_o=epc_i; next W_ERET, which writes addr 12 with status_i & ~32'h2, then IDLE.
REQ-024 stall_o SHALL equal (state != IDLE); flush_o SHALL be 0 outside IDLE.
REQ-025 In IDLE with no event, cp0_we/addr/wdata SHALL pass mtc0_* through combinationally; on an event cycle the MTC0 write SHALL be suppressed.
REQ-026 Outside IDLE, mtc0_* and all MEM inputs SHALL be ignored; no event nesting.
REQ-027 cp0_we=0 and cp0_hw_we=0 in every cycle not listed above.
REQ-028 Exception latency: flush cycle T; EPC write T+1, Cause T+2 (T+1 if EXL), Status T+3 (T+2).

Reset
REQ-029 While rst=0: state=IDLE, latches cleared, cp0_we=0, cp0_hw_we=0, cp0_waddr=0, cp0_wdata=0, flush_o=0, new_pc_o=0, stall_o=0, immediately and regardless of clk.
REQ-030 Reset asserted mid-sequence SHALL abort it; no partial write after release.

Structure
REQ-031 ExcCodes, state encodings and EXC_VECTOR default SHALL live in defines.v alongside existing CP0 register addresses.
REQ-032 Priority selection SHALL be a sub-module exc_prio (flags in, valid+code out).

Verification
REQ-033 syscall at pc=0x100, bd=0, EXL=0 -> flush, new_pc=0x20; writes EPC=0x100, Cause[6:2]=0x08, Status|=2 on T+1..T+3.
REQ-034 ovf at pc=0x204, bd=1 -> EPC=0x200, Cause[31]=1, Cause[6:2]=0x0c.
REQ-035 Status=0x0000_0401, Cause[10]=1, ri raised same cycle -> interrupt wins, code 0x00, EPC=pc.
REQ-036 break with Status.EXL=1 -> no EPC write; Cause T+1, Status T+2; stall 2 cycles.
REQ-037 ERET with epc_i=0x1234 -> new_pc=0x1234, next cycle Status write with EXL=0; concurrent mtc0_we suppressed.
REQ-038 rst low during W_CAUSE -> all outputs 0 at once; after release no Cause/Status write, state IDLE.
